// File: rtl/interrupt_sequencer.sv
// Fixed-priority, non-nesting interrupt sequencer that overrides the program sequencer's next address.
// Latency: a request edge reaches its vector 2 cycles later. Service and return slots each last 1 cycle.
// Backpressure: none. Masked or disabled requests stay pending until enabled.
module interrupt_sequencer #(
    parameter logic [7:0] VEC_BASE   = 8'hC0,
    parameter logic [7:0] VEC_STRIDE = 8'h10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] irq,
    input  logic       int_en,
    input  logic       mask_we,
    input  logic [3:0] mask_in,
    input  logic       rti,
    input  logic [7:0] pm_addr_in,
    output logic       force_valid,
    output logic [7:0] force_addr,
    output logic [3:0] ack,
    output logic [3:0] pending,
    output logic [3:0] mask,
    output logic       in_isr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VECTOR = 2'd1,
        IN_ISR = 2'd2,
        RETURN = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] irq_q;
    logic [7:0] ret_addr;
    logic [1:0] vec_idx;
    logic [1:0] win_idx;
    logic [3:0] rise;
    logic [3:0] clr;
    logic [3:0] eligible;
    logic [7:0] vec_addr;
    logic       take;

    assign rise     = irq & ~irq_q;
    assign eligible = pending & mask & {4{int_en}};
    assign clr      = (state == VECTOR) ? (4'b0001 << vec_idx) : 4'b0000;
    assign vec_addr = VEC_BASE + VEC_STRIDE * {6'd0, vec_idx};

    // Lowest index wins, so scan from the top down and let lower bits overwrite.
    always_comb begin
        win_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (eligible[i]) win_idx = 2'(i);
        end
    end

    always_comb begin
        state_nxt   = state;
        take        = 1'b0;
        force_valid = 1'b0;
        force_addr  = 8'h00;
        ack         = 4'b0000;
        in_isr      = 1'b0;
        case (state)
            IDLE: begin
                if (eligible != 4'b0000) begin
                    take      = 1'b1;
                    state_nxt = VECTOR;
                end
            end
            VECTOR: begin
                force_valid = 1'b1;
                force_addr  = vec_addr;
                ack         = 4'b0001 << vec_idx;
                state_nxt   = IN_ISR;
            end
            IN_ISR: begin
                in_isr = 1'b1;
                if (rti) state_nxt = RETURN;
            end
            RETURN: begin
                force_valid = 1'b1;
                force_addr  = ret_addr;
                in_isr      = 1'b1;
                // Tail-chain straight into the next vector without an idle gap.
                if (eligible != 4'b0000) begin
                    take      = 1'b1;
                    state_nxt = VECTOR;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            irq_q    <= 4'h0;
            pending  <= 4'h0;
            mask     <= 4'h0;
            ret_addr <= 8'h00;
            vec_idx  <= 2'd0;
        end else begin
            state   <= state_nxt;
            irq_q   <= irq;
            // A new edge landing on the bit being cleared must not be lost.
            pending <= (pending & ~clr) | rise;
            if (mask_we) mask <= mask_in;
            if (take) vec_idx <= win_idx;
            if (state == VECTOR) ret_addr <= pm_addr_in;
        end
    end

endmodule
